// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide data memory; sub-word stores are done as read-modify-write.
// Latency accept->resp_valid: load 2, word store 2, sub-word store 3, error 1; req_ready only in IDLE, no resp backpressure.
module mem_access_unit #(
    parameter logic [31:0] MEM_LO = 32'h0040_0000,
    parameter logic [31:0] MEM_HI = 32'h0040_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_addr,
    output logic [31:0] data_write_data,
    output logic        data_sig_mem_write,
    input  logic [31:0] data_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        data_we_q, data_we_d;

    logic        accept;
    logic        req_err;
    logic [1:0]  bytes_m1;
    logic [32:0] end_addr;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = (state_q == S_IDLE) && req_valid;

    // Request checks; end address is computed one bit wider so a wrap past 2^32 counts as out of bounds.
    always_comb begin
        case (req_size)
            2'd0:    bytes_m1 = 2'd0;
            2'd1:    bytes_m1 = 2'd1;
            default: bytes_m1 = 2'd3;
        endcase
        end_addr = {1'b0, req_addr} + {31'b0, bytes_m1};
        req_err  = (req_size == 2'd3)
                 || ((req_size == 2'd1) && req_addr[0])
                 || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                 || (req_addr < MEM_LO)
                 || (end_addr > {1'b0, MEM_HI});
    end

    always_comb begin
        lane_b = data_read_data[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? data_read_data[31:16] : data_read_data[15:0];
        case (size_q)
            2'd0:    load_ext = sgn_q ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            2'd1:    load_ext = sgn_q ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: load_ext = data_read_data;
        endcase
    end

    always_comb begin
        merged = data_read_data;
        case (size_q)
            2'd0: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_we_q    <= data_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                             state_d = S_RESP;
                    else if (req_write && req_size == 2'd2)  state_d = S_WRITE;
                    else                                     state_d = S_READ;
                end
            end
            S_READ:  state_d = write_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is the registered image of the state being entered, so the strobe is a clean flop.
    always_comb begin
        addr_d       = addr_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        data_we_d    = (state_d == S_WRITE);
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        if (accept) begin
            addr_d  = req_addr;
            size_d  = req_size;
            sgn_d   = req_signed;
            write_d = req_write;
            wdata_d = req_wdata;
            if (req_err) begin
                resp_error_d = 1'b1;
            end else begin
                data_addr_d = {req_addr[31:2], 2'b00};
                if (req_write && req_size == 2'd2) data_wdata_d = req_wdata;
            end
        end else if (state_q == S_READ) begin
            if (write_q) data_wdata_d = merged;
            else         resp_rdata_d = load_ext;
        end
    end

    assign req_ready          = req_ready_q;
    assign resp_valid         = resp_valid_q;
    assign resp_rdata         = resp_rdata_q;
    assign resp_error         = resp_error_q;
    assign data_addr          = data_addr_q;
    assign data_write_data    = data_wdata_q;
    assign data_sig_mem_write = data_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model; outputs sampled on the falling edge.
// Each request reports latency, strobe count and response fields, compared against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] data_addr, data_write_data, data_read_data;
    logic        data_sig_mem_write;

    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;
    logic [31:0] mem [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LO(32'h0040_0000), .MEM_HI(32'h0040_FFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .data_addr(data_addr), .data_write_data(data_write_data),
        .data_sig_mem_write(data_sig_mem_write), .data_read_data(data_read_data)
    );

    always @(posedge clk) begin
        if (poke_en)                 mem[poke_idx] <= poke_val;
        else if (data_sig_mem_write) mem[data_addr[9:2]] <= data_write_data;
    end
    assign data_read_data = mem[data_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one request from IDLE and watches up to 8 cycles for its response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e,
                          output int nstb, output logic [31:0] saddr, output logic [31:0] sdata);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_size = 2'd3; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        lat = 0; rd = '0; e = 1'b0; nstb = 0; saddr = '0; sdata = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (data_sig_mem_write) begin
                nstb++; saddr = data_addr; sdata = data_write_data;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; e = resp_error;
                break;
            end
        end
    endtask

    int          lat, nstb, nresp;
    logic [31:0] rd, saddr, sdata;
    logic        e, bad;
    logic [8:0]  rdy_bits;

    initial begin
        rst_n = 1'b0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_strobe", {31'b0, data_sig_mem_write}, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_wdata", data_write_data, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        poke(8'h04, 32'h80FF_7F01);
        poke(8'h05, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Loads from 0x00400010 = 0x80FF7F01
        do_req(1'b0, 2'd0, 1'b1, 32'h0040_0011, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lb_data", rd, 32'h0000_007F);
        chk("lb_lat", lat, 32'd2);
        chk("lb_nostrobe", nstb, 32'd0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0040_0012, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lh_data", rd, 32'hFFFF_80FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h0040_0012, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lhu_data", rd, 32'h0000_80FF);
        do_req(1'b0, 2'd0, 1'b0, 32'h0040_0013, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lbu_data", rd, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b1, 32'h0040_0010, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lh_lo_data", rd, 32'h0000_7F01);

        // Sub-word store via read-modify-write
        do_req(1'b1, 2'd0, 1'b0, 32'h0040_0012, 32'h0000_00AB, lat, rd, e, nstb, saddr, sdata);
        chk("sb_lat", lat, 32'd3);
        chk("sb_nstb", nstb, 32'd1);
        chk("sb_wdata", sdata, 32'h80AB_7F01);
        chk("sb_mem", mem[8'h04], 32'h80AB_7F01);
        chk("sb_rdata", rd, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0040_0012, 32'h0000_1234, lat, rd, e, nstb, saddr, sdata);
        chk("sh_mem", mem[8'h04], 32'h1234_7F01);
        poke(8'h04, 32'h80AB_7F01);

        // Word store
        do_req(1'b1, 2'd2, 1'b0, 32'h0040_0014, 32'hDEAD_BEEF, lat, rd, e, nstb, saddr, sdata);
        chk("sw_lat", lat, 32'd2);
        chk("sw_nstb", nstb, 32'd1);
        chk("sw_addr", saddr, 32'h0040_0014);
        chk("sw_mem", mem[8'h05], 32'hDEAD_BEEF);
        chk("sw_err", {31'b0, e}, 32'd0);

        // Error cases
        do_req(1'b0, 2'd1, 1'b1, 32'h0040_0001, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lh_mis_err", {31'b0, e}, 32'd1);
        chk("lh_mis_lat", lat, 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0040_FFFE, 32'h1111_1111, lat, rd, e, nstb, saddr, sdata);
        chk("sw_hi_err", {31'b0, e}, 32'd1);
        chk("sw_hi_lat", lat, 32'd1);
        chk("sw_hi_nstb", nstb, 32'd0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0040_FFFF, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lh_mis_top_err", {31'b0, e}, 32'd1);
        do_req(1'b0, 2'd0, 1'b0, 32'h0040_FFFF, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lb_top_ok", {31'b0, e}, 32'd0);
        do_req(1'b0, 2'd0, 1'b0, 32'h003F_FFFF, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lb_below_err", {31'b0, e}, 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h0040_0010, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("size3_err", {31'b0, e}, 32'd1);

        // Reset during the WRITE cycle of a sub-word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0040_0014; req_wdata = 32'h0000_0012;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_strobe_before", {31'b0, data_sig_mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobe_drop", {31'b0, data_sig_mem_write}, 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || data_sig_mem_write) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid || data_sig_mem_write) bad = 1'b1;
        end
        chk("rst_mid_quiet", {31'b0, bad}, 32'd0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_mem", mem[8'h05], 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0040_0014, 32'h0, lat, rd, e, nstb, saddr, sdata);
        chk("lw_after_rst", rd, 32'hDEAD_BEEF);

        // Back-to-back word loads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0040_0010;
        nresp = 0; rd = '0;
        for (int n = 0; n <= 8; n++) begin
            if (n > 0) @(negedge clk);
            rdy_bits[n] = req_ready;
            if (resp_valid) begin
                nresp++; rd = resp_rdata;
            end
        end
        req_valid = 1'b0;
        chk("b2b_ready_pattern", {23'b0, rdy_bits}, 32'h0000_0049);
        chk("b2b_nresp", nresp, 32'd3);
        chk("b2b_rdata", rd, 32'h80AB_7F01);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
